// File: rtl/m_irq_flag_arbiter.sv
// Interrupt flag bank with round-robin arbitration and an irq/ack/eoi handshake.
// Pending flags are set by peripheral strobes and cleared by software or by the CPU taking them.
module m_irq_flag_arbiter #(
  parameter  int NSRC = 4,
  localparam int VW   = $clog2(NSRC)
) (
  input  logic            MasterClock,
  input  logic            Reset,
  input  logic [NSRC-1:0] set_req,
  input  logic [NSRC-1:0] clr_req,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_d,
  input  logic            irq_ack,
  input  logic            eoi,
  output logic            irq,
  output logic [VW-1:0]   irq_vec,
  output logic [NSRC-1:0] pending,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} stateT;

  stateT           stateReg, stateNext;
  logic [NSRC-1:0] flagReg, flagNext;
  logic [NSRC-1:0] maskReg, maskNext;
  logic [VW-1:0]   rrReg, rrNext;
  logic [VW-1:0]   irqVecReg, irqVecNext;
  logic            irqReg, irqNext;
  logic            busyReg, busyNext;

  logic [NSRC-1:0] eligible;
  logic            anyEligible;
  logic [VW-1:0]   winner;
  logic            ackTake;
  logic            reqLive;
  int              idx;
  logic            found;

  assign eligible    = flagReg & ~maskReg;
  assign anyEligible = |eligible;
  assign ackTake     = (stateReg == REQ) && irq_ack;
  assign maskNext    = mask_we ? mask_d : maskReg;

  // Per-source SR flag: set dominates both software clear and the ack clear.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_flag
      logic clrBit;
      assign clrBit       = clr_req[gi] | (ackTake && (irqVecReg == VW'(gi)));
      assign flagNext[gi] = set_req[gi] | (flagReg[gi] & ~clrBit);
    end
  endgenerate

  // First eligible index starting at rr and wrapping modulo NSRC.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(rrReg) + k) % NSRC;
      if (!found && eligible[idx[VW-1:0]]) begin
        winner = idx[VW-1:0];
        found  = 1'b1;
      end
    end
  end

  // Request stays live only if the presented source is still flagged and unmasked after this edge,
  // so a clear or mask drops irq on the same edge instead of presenting a stale request.
  assign reqLive = (set_req[irqVecReg] | (flagReg[irqVecReg] & ~clr_req[irqVecReg]))
                   & ~maskNext[irqVecReg];

  assign rrNext = !ackTake                      ? rrReg :
                  (irqVecReg == VW'(NSRC - 1))  ? '0    : irqVecReg + VW'(1);

  always_comb begin
    stateNext  = stateReg;
    irqVecNext = irqVecReg;
    case (stateReg)
      IDLE: begin
        if (anyEligible) begin
          stateNext  = REQ;
          irqVecNext = winner;
        end
      end
      REQ: begin
        if (ackTake) begin
          stateNext = SERVICE;
        end else if (!reqLive) begin
          stateNext = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      stateReg  <= IDLE;
      flagReg   <= '0;
      maskReg   <= '1;
      rrReg     <= '0;
      irqVecReg <= '0;
      irqReg    <= 1'b0;
      busyReg   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      flagReg   <= flagNext;
      maskReg   <= maskNext;
      rrReg     <= rrNext;
      irqVecReg <= irqVecNext;
      irqReg    <= irqNext;
      busyReg   <= busyNext;
    end
  end

  always_comb begin
    irqNext  = (stateNext == REQ);
    busyNext = (stateNext == SERVICE);
    irq      = irqReg;
    busy     = busyReg;
    irq_vec  = irqVecReg;
    pending  = flagReg;
  end

endmodule

// File: tb/tb_m_irq_flag_arbiter.sv
// Directed bench for m_irq_flag_arbiter: vector table for grant ordering and masking,
// hand-written sequences for withdrawal, simultaneous set/ack and asynchronous reset.
module tb_m_irq_flag_arbiter;

  logic       MasterClock = 1'b0;
  logic       Reset;
  logic [3:0] set_req, clr_req, mask_d;
  logic       mask_we, irq_ack, eoi;
  logic       irq, busy;
  logic [1:0] irq_vec;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  always #5 MasterClock = ~MasterClock;

  m_irq_flag_arbiter #(.NSRC(4)) dut (
    .MasterClock(MasterClock),
    .Reset(Reset),
    .set_req(set_req),
    .clr_req(clr_req),
    .mask_we(mask_we),
    .mask_d(mask_d),
    .irq_ack(irq_ack),
    .eoi(eoi),
    .irq(irq),
    .irq_vec(irq_vec),
    .pending(pending),
    .busy(busy)
  );

  typedef struct {
    logic       rst;
    logic [3:0] setReq;
    logic [3:0] clrReq;
    logic       maskWe;
    logic [3:0] maskD;
    logic       ack;
    logic       eoi;
    logic       expIrq;
    logic [1:0] expVec;
    logic [3:0] expPend;
    logic       expBusy;
  } vecT;

  vecT tbl[$];

  task automatic add(input logic rst, input logic [3:0] s, input logic [3:0] c,
                     input logic mw, input logic [3:0] md, input logic a, input logic e,
                     input logic xIrq, input logic [1:0] xVec, input logic [3:0] xPend,
                     input logic xBusy);
    vecT v;
    v = '{rst, s, c, mw, md, a, e, xIrq, xVec, xPend, xBusy};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic eIrq, input logic [1:0] eVec,
                        input logic [3:0] ePend, input logic eBusy);
    chk({tag, ".irq"}, 32'(irq), 32'(eIrq));
    chk({tag, ".vec"}, 32'(irq_vec), 32'(eVec));
    chk({tag, ".pending"}, 32'(pending), 32'(ePend));
    chk({tag, ".busy"}, 32'(busy), 32'(eBusy));
    $display("%s: irq=%0b vec=%0d pending=%b busy=%0b", tag, irq, irq_vec, pending, busy);
  endtask

  // One clock edge; inputs are returned to idle 2 time units after it.
  task automatic tick();
    @(posedge MasterClock);
    #2;
    set_req = '0; clr_req = '0; mask_we = 1'b0; mask_d = '0; irq_ack = 1'b0; eoi = 1'b0;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
  endtask

  task automatic unmaskAll();
    mask_we = 1'b1;
    mask_d  = 4'b0000;
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    set_req = '0; clr_req = '0; mask_we = 1'b0; mask_d = '0; irq_ack = 1'b0; eoi = 1'b0;
    #12;
    chkOut("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    Reset = 1'b0;

    //  rst  set      clr      mw    maskD    ack   eoi   irq   vec   pend     busy
    // single source, latency and handshake
    add(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0);
    // round robin over all four, then 0,1 again after rr wraps to 0
    add(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1111, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1110, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1110, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1110, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1100, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b1100, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b1100, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'b1000, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0);
    add(1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0011, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0011, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0);
    // masked source pends silently, stray ack in IDLE ignored, unmask raises irq
    add(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) doReset();
      set_req = tbl[i].setReq;
      clr_req = tbl[i].clrReq;
      mask_we = tbl[i].maskWe;
      mask_d  = tbl[i].maskD;
      irq_ack = tbl[i].ack;
      eoi     = tbl[i].eoi;
      tick();
      chkOut($sformatf("row%0d", i), tbl[i].expIrq, tbl[i].expVec, tbl[i].expPend, tbl[i].expBusy);
    end

    // withdrawal by software clear, then by masking
    doReset();
    unmaskAll();
    set_req = 4'b0010; tick();
    tick();
    chkOut("wd_req", 1'b1, 2'd1, 4'b0010, 1'b0);
    clr_req = 4'b0010; tick();
    chkOut("wd_clr", 1'b0, 2'd1, 4'b0000, 1'b0);
    tick();
    chkOut("wd_idle", 1'b0, 2'd1, 4'b0000, 1'b0);
    set_req = 4'b0110; tick();
    tick();
    chkOut("wd_rr", 1'b1, 2'd1, 4'b0110, 1'b0);
    mask_we = 1'b1; mask_d = 4'b0010; tick();
    chkOut("wd_mask", 1'b0, 2'd1, 4'b0110, 1'b0);
    tick();
    chkOut("wd_next", 1'b1, 2'd2, 4'b0110, 1'b0);

    // set and ack on the same source; ack beats a same-cycle clear
    doReset();
    unmaskAll();
    set_req = 4'b1000; tick();
    tick();
    chkOut("sim_req", 1'b1, 2'd3, 4'b1000, 1'b0);
    irq_ack = 1'b1; set_req = 4'b1000; tick();
    chkOut("sim_ackset", 1'b0, 2'd3, 4'b1000, 1'b1);
    eoi = 1'b1; tick();
    chkOut("sim_eoi", 1'b0, 2'd3, 4'b1000, 1'b0);
    tick();
    chkOut("sim_rereq", 1'b1, 2'd3, 4'b1000, 1'b0);
    irq_ack = 1'b1; clr_req = 4'b1000; tick();
    chkOut("sim_ackclr", 1'b0, 2'd3, 4'b0000, 1'b1);
    eoi = 1'b1; tick();
    chkOut("sim_done", 1'b0, 2'd3, 4'b0000, 1'b0);

    // asynchronous reset mid-SERVICE
    doReset();
    unmaskAll();
    set_req = 4'b1010; tick();
    tick();
    chkOut("ar_req", 1'b1, 2'd1, 4'b1010, 1'b0);
    irq_ack = 1'b1; set_req = 4'b0010; tick();
    chkOut("ar_svc", 1'b0, 2'd1, 4'b1010, 1'b1);
    #1 Reset = 1'b1;
    #1 chkOut("ar_async", 1'b0, 2'd0, 4'b0000, 1'b0);
    #1 Reset = 1'b0;
    eoi = 1'b1; tick();
    chkOut("ar_strayeoi", 1'b0, 2'd0, 4'b0000, 1'b0);
    set_req = 4'b0001; tick();
    chkOut("ar_masked", 1'b0, 2'd0, 4'b0001, 1'b0);
    tick();
    chkOut("ar_stillmasked", 1'b0, 2'd0, 4'b0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
